// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: round-robin arbiter that shares one 32-bit SDRAM read
// port among N ROM requesters. One transaction is in flight at a time; the
// read word comes back with a one-cycle done pulse on the owning slot.
// Slots in PRIO_MASK take precedence during active video, a watchdog aborts
// reads whose data never arrives, and refresh is enabled whenever the port
// has nothing to do.
module jtframe_sdram_arb #(
    parameter int           N         = 4,
    parameter int           AW        = 22,
    parameter logic [N-1:0] PRIO_MASK = 4'b0011,
    parameter logic [7:0]   WDOG      = 8'd255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vblank,
    input  logic            downloading,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] addr,
    output logic [N-1:0]    done,
    output logic [31:0]     dout,
    output logic            sdram_req,
    input  logic            sdram_ack,
    input  logic            data_rdy,
    output logic [AW-1:0]   sdram_addr,
    input  logic [31:0]     data_read,
    output logic            refresh_en,
    output logic            busy,
    output logic            err
);

    localparam int RW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t          state_r;
    logic [RW-1:0]   rr_r;
    logic [RW-1:0]   cur_r;
    logic [N-1:0]    hold_r;
    logic [7:0]      wdog_r;

    logic [N-1:0]    elig_s;
    logic [N-1:0]    prio_s;
    logic [N-1:0]    cand_s;
    logic [RW:0]     pick_s;
    logic            win_vld_s;
    logic [RW-1:0]   win_idx_s;
    logic [AW-1:0]   addr_sel_s;

    // Round-robin search: the first candidate found scanning upward from
    // ptr+1 with wrap-around. Scanning the offsets from far to near lets the
    // nearest hit overwrite the others, so no early exit is needed.
    function automatic logic [RW:0] pick_winner(input logic [N-1:0]  cand,
                                                input logic [RW-1:0] ptr);
        logic [RW:0]   res;
        logic [RW-1:0] pos_idx;
        int            pos;
        res = '0;
        for (int k = N; k >= 1; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end else begin
                pos = pos;
            end
            pos_idx = pos[RW-1:0];
            if (cand[pos_idx]) begin
                res = {1'b1, pos_idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // One-hot encoding of a slot index.
    function automatic logic [N-1:0] to_onehot(input logic [RW-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == RW'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Candidate set: a just-served slot sits out one evaluation, and during
    // active video the boosted slots win whenever any of them is eligible.
    always_comb begin
        elig_s = req & ~hold_r;
        prio_s = elig_s & PRIO_MASK;
        if (!vblank && (prio_s != '0)) begin
            cand_s = prio_s;
        end else begin
            cand_s = elig_s;
        end
    end

    // Winner of the current arbitration round.
    always_comb begin
        pick_s    = pick_winner(cand_s, rr_r);
        win_vld_s = pick_s[RW];
        win_idx_s = pick_s[RW-1:0];
    end

    // Address of the winning slot taken from the flattened address bus.
    always_comb begin
        addr_sel_s = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx_s == RW'(i)) begin
                addr_sel_s = addr[AW*i +: AW];
            end else begin
                addr_sel_s = addr_sel_s;
            end
        end
    end

    // Transaction sequencer: arbitration, SDRAM handshake, data return,
    // watchdog abort and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rr_r       <= RW'(N-1);
            cur_r      <= '0;
            hold_r     <= '0;
            wdog_r     <= 8'd0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            done       <= '0;
            dout       <= 32'd0;
            refresh_en <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done       <= '0;
            err        <= 1'b0;
            hold_r     <= '0;
            refresh_en <= (state_r == IDLE) && (cand_s == '0) && !downloading;
            case (state_r)
                IDLE: begin
                    if (win_vld_s && !downloading) begin
                        state_r    <= WAIT_ACK;
                        sdram_req  <= 1'b1;
                        sdram_addr <= addr_sel_s;
                        cur_r      <= win_idx_s;
                        rr_r       <= win_idx_s;
                        busy       <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    // a data strobe coinciding with the ack belongs to nobody
                    if (sdram_ack) begin
                        state_r   <= WAIT_DATA;
                        sdram_req <= 1'b0;
                        wdog_r    <= 8'd0;
                    end else begin
                        state_r   <= WAIT_ACK;
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        dout    <= data_read;
                        done    <= to_onehot(cur_r);
                        hold_r  <= to_onehot(cur_r);
                    end else if ((wdog_r + 8'd1) == WDOG) begin
                        // abandon the read; the slot keeps requesting and is
                        // picked up again by normal arbitration
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        wdog_r  <= 8'd0;
                    end else begin
                        wdog_r  <= wdog_r + 8'd1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    sdram_req <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Self-checking bench for jtframe_sdram_arb: the bench plays the SDRAM
// controller with random latencies and predicts every grant from the
// arbitration rules (eligibility, video boost, round-robin order).
module tb_jtframe_sdram_arb;

    localparam int N  = 4;
    localparam int AW = 22;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            vblank = 1'b0;
    logic            downloading = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] addr;
    logic [N-1:0]    done;
    logic [31:0]     dout;
    logic            sdram_req;
    logic            sdram_ack = 1'b0;
    logic            data_rdy = 1'b0;
    logic [AW-1:0]   sdram_addr;
    logic [31:0]     data_read = 32'd0;
    logic            refresh_en;
    logic            busy;
    logic            err;

    logic [AW-1:0]   addr_arr [N];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              rr_m;
    logic [N-1:0]    hold_m;

    jtframe_sdram_arb dut (
        .clk         (clk),
        .rst         (rst),
        .vblank      (vblank),
        .downloading (downloading),
        .req         (req),
        .addr        (addr),
        .done        (done),
        .dout        (dout),
        .sdram_req   (sdram_req),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .sdram_addr  (sdram_addr),
        .data_read   (data_read),
        .refresh_en  (refresh_en),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    always_comb begin
        addr = '0;
        for (int i = 0; i < N; i++) addr[AW*i +: AW] = addr_arr[i];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: build the service order starting after the
    // last winner and return the first slot that may be served.
    function automatic int model_pick(input logic [N-1:0] r, input logic [N-1:0] hold,
                                      input bit vb, input int rr);
        int order[$];
        int boosted[$];
        int plain[$];
        for (int k = 1; k <= N; k++) order.push_back((rr + k) % N);
        foreach (order[j]) begin
            if (r[order[j]] && !hold[order[j]]) begin
                if (order[j] <= 1) boosted.push_back(order[j]);
                plain.push_back(order[j]);
            end
        end
        if (!vb && boosted.size() > 0) return boosted[0];
        if (plain.size() > 0) return plain[0];
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i] === 1'b1) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic go_idle;
        req = '0;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        repeat (3) tick;
        hold_m = '0;
    endtask

    function automatic int predict(input logic [N-1:0] r, input bit vb);
        int w;
        w = model_pick(r, hold_m, vb, rr_m);
        if (w < 0) w = model_pick(r, '0, vb, rr_m);
        return w;
    endfunction

    // Acts as the SDRAM controller for one transaction and reports what the
    // arbiter did; ok=0 means the request never showed up.
    task automatic run_txn(input int ack_dly, input int rdy_dly, input logic [31:0] d,
                           input bit dual, input bit drop,
                           output int slot, output logic [AW-1:0] a_obs,
                           output logic [31:0] dout_obs, output bit ok);
        int cnt = 0;
        ok = 1'b1;
        slot = -1;
        a_obs = '0;
        dout_obs = '0;
        while (sdram_req !== 1'b1 && cnt < 50) begin
            tick;
            cnt++;
        end
        if (sdram_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        a_obs = sdram_addr;
        repeat (ack_dly) tick;
        sdram_ack = 1'b1;
        if (dual) begin
            data_rdy = 1'b1;
            data_read = ~d;
        end
        tick;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        if (drop) req = '0;
        repeat (rdy_dly) tick;
        data_rdy = 1'b1;
        data_read = d;
        tick;
        data_rdy = 1'b0;
        slot = onehot_idx(done);
        dout_obs = dout;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        n_cmp++;
        if ({sdram_req, busy, err, refresh_en} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {sdram_req, busy, err, refresh_en});
        end
        n_cmp++;
        if (done !== 4'b0000 || dout !== 32'd0 || sdram_addr !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_data: done=%b dout=%h addr=%h expected zeros", done, dout, sdram_addr);
        end
        tick;
        n_cmp++;
        if (refresh_en !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_refresh: got %b expected 1", refresh_en);
        end
        rr_m = N - 1;
        hold_m = '0;
    endtask

    task automatic test_round_robin;
        int slot;
        logic [AW-1:0] a;
        logic [31:0] dv, d;
        bit ok;
        logic [N-1:0] served = '0;
        for (int i = 0; i < N; i++) addr_arr[i] = {2'(i), 20'($urandom)};
        vblank = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            d = $urandom;
            run_txn(1, 1, d, 1'b0, 1'b0, slot, a, dv, ok);
            n_cmp++;
            if (!ok || slot !== k || served[k[1:0]]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got slot %0d ok=%0d expected slot %0d", k, slot, ok, k);
            end
            n_cmp++;
            if (a !== addr_arr[k] || dv !== d) begin
                n_bad++;
                $display("FAIL rr_data[%0d]: got addr %h dout %h expected %h %h", k, a, dv, addr_arr[k], d);
            end
            if (slot >= 0) begin
                served[slot] = 1'b1;
                req[slot] = 1'b0;
            end
        end
        rr_m = N - 1;
        go_idle;
    endtask

    task automatic test_single;
        vblank = 1'b1;
        addr_arr[2] = 22'h0E000;
        req = 4'b0100;
        tick;
        n_cmp++;
        if (sdram_req !== 1'b1 || sdram_addr !== 22'h0E000 || busy !== 1'b1 || refresh_en !== 1'b0) begin
            n_bad++;
            $display("FAIL single_issue: req=%b addr=%h busy=%b ref=%b expected 1 0e000 1 0",
                     sdram_req, sdram_addr, busy, refresh_en);
        end
        tick;
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        n_cmp++;
        if (sdram_req !== 1'b0) begin
            n_bad++;
            $display("FAIL single_ack: sdram_req got %b expected 0", sdram_req);
        end
        repeat (4) tick;
        data_rdy = 1'b1;
        data_read = 32'hDEADBEEF;
        tick;
        data_rdy = 1'b0;
        req = '0;
        n_cmp++;
        if (done !== 4'b0100 || dout !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL single_done: done=%b dout=%h expected 0100 deadbeef", done, dout);
        end
        tick;
        n_cmp++;
        if (done !== 4'b0000 || dout !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL single_pulse: done=%b dout=%h expected 0000 deadbeef", done, dout);
        end
        rr_m = 2;
        go_idle;
    endtask

    task automatic test_priority;
        int slot, exp, n3;
        logic [AW-1:0] a;
        logic [31:0] dv;
        bit ok;
        vblank = 1'b0;
        req = 4'b1101;
        n3 = 0;
        for (int k = 0; k < 6; k++) begin
            exp = predict(req, 1'b0);
            run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom, 1'b0, 1'b0, slot, a, dv, ok);
            n_cmp++;
            if (!ok || slot !== exp || slot !== ((k % 2) * 2)) begin
                n_bad++;
                $display("FAIL prio_order[%0d]: got slot %0d expected %0d", k, slot, (k % 2) * 2);
            end
            if (slot == 3) n3++;
            rr_m = exp;
            hold_m = '0;
            hold_m[exp] = 1'b1;
        end
        n_cmp++;
        if (n3 != 0) begin
            n_bad++;
            $display("FAIL prio_starve: slot 3 served %0d times expected 0", n3);
        end
        vblank = 1'b1;
        n3 = 0;
        for (int k = 0; k < 3; k++) begin
            exp = predict(req, 1'b1);
            run_txn(0, 0, $urandom, 1'b0, 1'b0, slot, a, dv, ok);
            if (slot == 3) n3++;
            rr_m = exp;
            hold_m = '0;
            hold_m[exp] = 1'b1;
        end
        n_cmp++;
        if (n3 == 0) begin
            n_bad++;
            $display("FAIL prio_vblank: slot 3 served %0d times in 3 expected >0", n3);
        end
        go_idle;
    endtask

    task automatic test_watchdog;
        int n, cnt, slot;
        bit done_seen, ok;
        logic [AW-1:0] a0, a;
        logic [31:0] dv, d;
        vblank = 1'b1;
        req = 4'b0010;
        cnt = 0;
        while (sdram_req !== 1'b1 && cnt < 20) begin
            tick;
            cnt++;
        end
        a0 = sdram_addr;
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        n = 1;
        done_seen = 1'b0;
        while (err !== 1'b1 && n < 400) begin
            if (done !== 4'b0000) done_seen = 1'b1;
            tick;
            n++;
        end
        n_cmp++;
        if (n != 256) begin
            n_bad++;
            $display("FAIL wdog_time: err after %0d cycles expected 256", n);
        end
        n_cmp++;
        if (done_seen || done !== 4'b0000) begin
            n_bad++;
            $display("FAIL wdog_done: done seen=%0d expected 0", done_seen);
        end
        tick;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_pulse: err got %b expected 0", err);
        end
        d = $urandom;
        run_txn(1, 2, d, 1'b0, 1'b0, slot, a, dv, ok);
        n_cmp++;
        if (!ok || slot !== 1 || a !== a0 || a0 !== addr_arr[1] || dv !== d) begin
            n_bad++;
            $display("FAIL wdog_retry: slot %0d addr %h expected slot 1 addr %h", slot, a, addr_arr[1]);
        end
        rr_m = 1;
        go_idle;
    endtask

    task automatic test_download;
        int cnt;
        logic [31:0] d;
        vblank = 1'b1;
        req = 4'b1000;
        cnt = 0;
        while (sdram_req !== 1'b1 && cnt < 20) begin
            tick;
            cnt++;
        end
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        downloading = 1'b1;
        req = 4'b1011;
        repeat (2) tick;
        d = $urandom;
        data_rdy = 1'b1;
        data_read = d;
        tick;
        data_rdy = 1'b0;
        req = 4'b0011;
        n_cmp++;
        if (done !== 4'b1000 || dout !== d) begin
            n_bad++;
            $display("FAIL dl_done: done=%b dout=%h expected 1000 %h", done, dout, d);
        end
        for (int k = 0; k < 8; k++) begin
            tick;
            n_cmp++;
            if (sdram_req !== 1'b0 || refresh_en !== 1'b0) begin
                n_bad++;
                $display("FAIL dl_block[%0d]: sdram_req=%b refresh_en=%b expected 0 0", k, sdram_req, refresh_en);
            end
        end
        req = '0;
        downloading = 1'b0;
        repeat (2) tick;
        n_cmp++;
        if (refresh_en !== 1'b1) begin
            n_bad++;
            $display("FAIL dl_refresh: refresh_en got %b expected 1", refresh_en);
        end
        rr_m = 3;
        go_idle;
    endtask

    task automatic test_random;
        int slot, exp;
        logic [AW-1:0] a;
        logic [31:0] dv, d;
        logic [N-1:0] r;
        bit ok, vb, drop;
        for (int i = 0; i < N; i++) addr_arr[i] = {2'(i), 20'($urandom)};
        for (int it = 0; it < 30; it++) begin
            r = 4'($urandom_range(1, 15));
            vb = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0);
            req = r;
            vblank = vb;
            exp = predict(r, vb);
            d = $urandom;
            run_txn($urandom_range(0, 3), $urandom_range(0, 4), d, 1'($urandom_range(0, 1)), drop,
                    slot, a, dv, ok);
            n_cmp++;
            if (!ok || slot !== exp || exp < 0) begin
                n_bad++;
                $display("FAIL rand_slot[%0d]: req=%b vb=%0d got slot %0d expected %0d", it, r, vb, slot, exp);
            end else begin
                n_cmp++;
                if (a !== addr_arr[exp] || dv !== d) begin
                    n_bad++;
                    $display("FAIL rand_data[%0d]: addr %h dout %h expected %h %h", it, a, dv, addr_arr[exp], d);
                end
            end
            if (exp >= 0) begin
                rr_m = exp;
                hold_m = '0;
                hold_m[exp] = 1'b1;
            end
        end
        go_idle;
    endtask

    task automatic test_async_reset;
        int cnt = 0;
        vblank = 1'b1;
        req = 4'b0001;
        while (sdram_req !== 1'b1 && cnt < 20) begin
            tick;
            cnt++;
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (sdram_req !== 1'b0 || busy !== 1'b0 || refresh_en !== 1'b0 || sdram_addr !== 22'd0) begin
            n_bad++;
            $display("FAIL arst_clear: req=%b busy=%b ref=%b addr=%h expected 0 0 0 0",
                     sdram_req, busy, refresh_en, sdram_addr);
        end
        req = '0;
        tick;
        rst = 1'b0;
        sdram_ack = 1'b1;
        data_rdy = 1'b1;
        data_read = 32'h12345678;
        tick;
        sdram_ack = 1'b0;
        data_rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (done !== 4'b0000 || busy !== 1'b0 || dout !== 32'd0) begin
                n_bad++;
                $display("FAIL arst_late[%0d]: done=%b busy=%b dout=%h expected 0 0 0", k, done, busy, dout);
            end
            tick;
        end
        rr_m = N - 1;
        hold_m = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) addr_arr[i] = '0;
        test_reset;
        test_round_robin;
        test_single;
        test_priority;
        test_watchdog;
        test_download;
        test_random;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
